dice_game_ctrl: RTL and testbench
=================================

// Module: dice_game_ctrl
// PURPOSE
//   Craps rule controller for the dice game datapath. Enables the dice counters while the
//   roll button is held, then judges each completed roll against the sum from the dice adder.
//   It keeps the point and the roll count, and drives win/lose until a new game is requested.
//   The game test driver connects directly to Rb_i/Reset_i/sum_i and to win_o/lose_o.
// PARAMETERS
//   SUM_W   4   width of dice sum bus (legal sums 2..12)
//   CNT_W   4   width of completed-roll counter (saturating)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst       in   1      asynchronous, active-high reset
//   Rb_i      in   1      roll button; high = dice rolling requested
//   Reset_i   in   1      new-game request; honoured only in WIN/LOSE
//   sum_i     in   SUM_W  current dice sum from datapath
//   roll_o    out  1      enable to dice counters (Moore)
//   win_o     out  1      game won (Moore)
//   lose_o    out  1      game lost (Moore)
//   point_o   out  SUM_W  stored point; 0 when no point is set
//   nroll_o   out  CNT_W  legal rolls completed in current game
// BEHAVIOUR
//   Clock and reset: single clock domain. rst asserted -> state IDLE1; roll_o=win_o=lose_o=0,
//     point_o=0, nroll_o=0, all immediately. Reset mid-roll aborts the game with no residue.
//   States:
//     IDLE1  wait first roll; Rb_i=1 -> ROLL1
//     ROLL1  roll_o=1; Rb_i=1 -> stay; Rb_i=0 -> judge sum_i in the same cycle:
//            7|11 -> WIN; 2|3|12 -> LOSE; 4,5,6,8,9,10 -> point<=sum_i, IDLE2;
//            illegal (0,1,13..15) -> IDLE1, point and count unchanged
//     IDLE2  wait next roll; Rb_i=1 -> ROLL2
//     ROLL2  roll_o=1; Rb_i=0 -> judge: sum_i==point -> WIN; 7 -> LOSE;
//            other legal sum -> IDLE2; illegal sum -> IDLE2, no count
//     WIN    win_o=1; Reset_i=1 -> IDLE1. Rb_i is ignored.
//     LOSE   lose_o=1; Reset_i=1 -> IDLE1. Rb_i is ignored.
//   Latency: roll_o rises 1 cycle after Rb_i rises. roll_o falls 1 cycle after Rb_i falls.
//     win_o/lose_o assert in the cycle after the judging edge.
//   Reset_i outside WIN/LOSE is ignored. Reset_i and Rb_i high together in WIN/LOSE: Reset_i
//     wins -> IDLE1 next cycle.
//   nroll_o: +1 on each legal judgement (including the deciding roll). Saturates at
//     2^CNT_W-1 with no wrap. Cleared together with point_o on WIN/LOSE -> IDLE1.
//   Arithmetic: sum_i compared unsigned at full SUM_W. Point compare is exact equality.
//   sum_i is sampled only in the judging cycle; it may change freely while roll_o=1.
// STRUCTURE
//   dice_pkg: state localparams (IDLE1..LOSE, 3-bit), SUM_MIN=2, SUM_MAX=12, SUM_SEVEN=7,
//     SUM_ELEVEN=11, craps set {2,3,12}.
//   Sub-module dice_rule_eval (combinational): inputs sum, point, first_roll.
//     Outputs is_legal, is_win, is_lose.
//   Top: state register, point register and roll counter, next-state logic, Moore outputs.
// TESTING
//   1 rst=1 in any state -> all outputs 0 within the cycle; release -> IDLE1, roll_o=0
//   2 Rb_i high 3 cycles, sum_i=7 at release -> roll_o high 3 cycles; win_o=1, nroll_o=1
//   3 first roll 2 -> lose_o=1. New game via Reset_i: 4 then 7 -> point_o=4, lose_o=1, nroll_o=2
//   4 rolls 5,6,8,5 -> point_o=5 after first, no decision on 6/8, win_o on fourth, nroll_o=4
//   5 in WIN: Reset_i=1 and Rb_i=1 together -> IDLE1 next cycle, point_o=0, nroll_o=0, roll_o=0
//   6 first roll sum_i=13 -> back to IDLE1, nroll_o=0. Then 16 non-deciding rolls (point 6,
//     sum 8) -> nroll_o saturates at 15

Source files
------------

// File: rtl/dice_pkg.sv
// Shared constants and types for the craps rule controller.
// State codes, legal-sum bounds and the craps-sum helper live here.
package dice_pkg;

  localparam logic [2:0] ST_IDLE1 = 3'd0;
  localparam logic [2:0] ST_ROLL1 = 3'd1;
  localparam logic [2:0] ST_IDLE2 = 3'd2;
  localparam logic [2:0] ST_ROLL2 = 3'd3;
  localparam logic [2:0] ST_WIN   = 3'd4;
  localparam logic [2:0] ST_LOSE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE1 = ST_IDLE1,
    ROLL1 = ST_ROLL1,
    IDLE2 = ST_IDLE2,
    ROLL2 = ST_ROLL2,
    WIN   = ST_WIN,
    LOSE  = ST_LOSE
  } state_e;

  localparam int unsigned SUM_MIN    = 2;
  localparam int unsigned SUM_MAX    = 12;
  localparam int unsigned SUM_SEVEN  = 7;
  localparam int unsigned SUM_ELEVEN = 11;

  // Sums that lose on the come-out roll.
  function automatic logic is_craps_sum(input int unsigned s);
    return (s == 2) || (s == 3) || (s == 12);
  endfunction

endpackage

// File: rtl/dice_rule_eval.sv
// Combinational judgement of one completed roll.
// first_roll selects come-out rules; otherwise the sum is matched against the point.
module dice_rule_eval
  import dice_pkg::*;
#(
  parameter int SUM_W = 4
) (
  input  logic [SUM_W-1:0] sum,
  input  logic [SUM_W-1:0] point,
  input  logic             first_roll,
  output logic             is_legal,
  output logic             is_win,
  output logic             is_lose
);

  logic [31:0] sum_u;
  logic [31:0] point_u;

  assign sum_u   = 32'(sum);
  assign point_u = 32'(point);

  always_comb begin
    is_legal = (sum_u >= SUM_MIN) && (sum_u <= SUM_MAX);
    is_win   = 1'b0;
    is_lose  = 1'b0;
    if (first_roll) begin
      is_win  = is_legal && ((sum_u == SUM_SEVEN) || (sum_u == SUM_ELEVEN));
      is_lose = is_legal && is_craps_sum(sum_u);
    end else begin
      is_win  = is_legal && (sum_u == point_u);
      is_lose = is_legal && (sum_u == SUM_SEVEN);
    end
  end

endmodule

// File: rtl/dice_game_ctrl.sv
// Craps rule controller: gates the dice counters while the button is held,
// judges each completed roll, and tracks the point and roll count until a new game.
module dice_game_ctrl
  import dice_pkg::*;
#(
  parameter int SUM_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Rb_i,
  input  logic             Reset_i,
  input  logic [SUM_W-1:0] sum_i,
  output logic             roll_o,
  output logic             win_o,
  output logic             lose_o,
  output logic [SUM_W-1:0] point_o,
  output logic [CNT_W-1:0] nroll_o
);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] point_q, point_d;
  logic [CNT_W-1:0] nroll_q, nroll_d;
  logic             count_en;
  logic             first_roll;
  logic             is_legal, is_win, is_lose;

  assign first_roll = (state_q == ROLL1);

  dice_rule_eval #(
    .SUM_W (SUM_W)
  ) u_rule_eval (
    .sum        (sum_i),
    .point      (point_q),
    .first_roll (first_roll),
    .is_legal   (is_legal),
    .is_win     (is_win),
    .is_lose    (is_lose)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE1;
      point_q <= '0;
      nroll_q <= '0;
    end else begin
      state_q <= state_d;
      point_q <= point_d;
      nroll_q <= nroll_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    point_d  = point_q;
    nroll_d  = nroll_q;
    count_en = 1'b0;

    unique case (state_q)
      IDLE1: if (Rb_i) state_d = ROLL1;
      ROLL1: begin
        if (!Rb_i) begin
          state_d = IDLE1;
          if (is_legal) begin
            count_en = 1'b1;
            if (is_win)       state_d = WIN;
            else if (is_lose) state_d = LOSE;
            else begin
              point_d = sum_i;
              state_d = IDLE2;
            end
          end
        end
      end
      IDLE2: if (Rb_i) state_d = ROLL2;
      ROLL2: begin
        if (!Rb_i) begin
          state_d  = IDLE2;
          count_en = is_legal;
          if (is_win)       state_d = WIN;
          else if (is_lose) state_d = LOSE;
        end
      end
      WIN, LOSE: begin
        // New game wipes the point and roll count together.
        if (Reset_i) begin
          state_d = IDLE1;
          point_d = '0;
          nroll_d = '0;
        end
      end
      default: state_d = IDLE1;
    endcase

    if (count_en && (nroll_q != '1)) nroll_d = nroll_q + 1'b1;
  end

  assign roll_o  = (state_q == ROLL1) || (state_q == ROLL2);
  assign win_o   = (state_q == WIN);
  assign lose_o  = (state_q == LOSE);
  assign point_o = point_q;
  assign nroll_o = nroll_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: directed vector table, hand sequences
// for reset and counter saturation, and randomized play against a game model.
module tb_dice_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       Rb_i;
  logic       Reset_i;
  logic [3:0] sum_i;
  logic       roll_o, win_o, lose_o;
  logic [3:0] point_o;
  logic [3:0] nroll_o;

  int checks = 0;
  int errors = 0;

  dice_game_ctrl #(.SUM_W(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .Rb_i    (Rb_i),
    .Reset_i (Reset_i),
    .sum_i   (sum_i),
    .roll_o  (roll_o),
    .win_o   (win_o),
    .lose_o  (lose_o),
    .point_o (point_o),
    .nroll_o (nroll_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rb;
    logic       rs;
    logic [3:0] sum;
    logic       e_roll;
    logic       e_win;
    logic       e_lose;
    logic [3:0] e_point;
    logic [3:0] e_nroll;
  } vec_t;

  vec_t vecs[$];

  // Game model: a game is a point (0 = none), a result, and whether dice are rolling.
  int m_point, m_nroll, m_result;
  bit m_rolling;

  task automatic model_reset();
    m_point = 0; m_nroll = 0; m_result = 0; m_rolling = 0;
  endtask

  task automatic model_judge(input int s);
    if (s >= 2 && s <= 12) begin
      if (m_nroll < 15) m_nroll++;
      if (m_point == 0) begin
        if (s == 7 || s == 11) m_result = 1;
        else if (s == 2 || s == 3 || s == 12) m_result = 2;
        else m_point = s;
      end else if (s == m_point) m_result = 1;
      else if (s == 7) m_result = 2;
    end
  endtask

  task automatic model_step(input bit rb, input bit rs, input int s);
    if (m_result != 0) begin
      if (rs) model_reset();
    end else if (!m_rolling) begin
      if (rb) m_rolling = 1;
    end else if (!rb) begin
      m_rolling = 0;
      model_judge(s);
    end
  endtask

  function automatic logic [10:0] model_out();
    return {m_rolling, (m_result == 1), (m_result == 2), 4'(m_point), 4'(m_nroll)};
  endfunction

  function automatic logic [10:0] dut_out();
    return {roll_o, win_o, lose_o, point_o, nroll_o};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = dut_out();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: roll/win/lose/point/nroll got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
               name, act[10], act[9], act[8], act[7:4], act[3:0],
               exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic rb, input logic rs, input logic [3:0] s);
    Rb_i = rb; Reset_i = rs; sum_i = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rb, input logic rs, input int s, input logic r,
                     input logic w, input logic l, input int p, input int n);
    vec_t v;
    v.rb = rb; v.rs = rs; v.sum = 4'(s);
    v.e_roll = r; v.e_win = w; v.e_lose = l; v.e_point = 4'(p); v.e_nroll = 4'(n);
    vecs.push_back(v);
  endtask

  task automatic async_reset_check(input string name);
    #2 rst = 1'b1;
    #1 check(name, 11'b0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Rb_i = 1'b0; Reset_i = 1'b0; sum_i = '0;
    #12;
    check("reset_hold", 11'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release_idle", 11'b0);

    // Reset in the middle of a roll leaves nothing behind.
    drive(1, 0, 0);
    check("roll_start", {1'b1, 2'b00, 4'd0, 4'd0});
    async_reset_check("reset_mid_roll");
    drive(0, 0, 7);
    check("after_mid_roll_reset", 11'b0);

    // rb rs sum | roll win lose point nroll
    add(1,0,0,  1,0,0,0,0); add(1,0,3,  1,0,0,0,0); add(1,0,12, 1,0,0,0,0);
    add(0,0,7,  0,1,0,0,1); add(1,0,0,  0,1,0,0,1); add(0,1,0,  0,0,0,0,0);
    add(1,0,0,  1,0,0,0,0); add(0,0,2,  0,0,1,0,1); add(0,1,0,  0,0,0,0,0);
    add(1,0,0,  1,0,0,0,0); add(0,0,4,  0,0,0,4,1); add(0,1,7,  0,0,0,4,1);
    add(1,0,0,  1,0,0,4,1); add(0,0,7,  0,0,1,4,2); add(0,1,0,  0,0,0,0,0);
    add(1,0,0,  1,0,0,0,0); add(0,0,5,  0,0,0,5,1); add(1,0,0,  1,0,0,5,1);
    add(0,0,6,  0,0,0,5,2); add(1,0,0,  1,0,0,5,2); add(0,0,8,  0,0,0,5,3);
    add(1,0,0,  1,0,0,5,3); add(0,0,5,  0,1,0,5,4); add(1,1,0,  0,0,0,0,0);
    add(1,0,0,  1,0,0,0,0); add(0,0,4,  0,0,0,4,1); add(1,0,0,  1,0,0,4,1);
    add(0,0,13, 0,0,0,4,1); add(1,0,0,  1,0,0,4,1); add(0,0,0,  0,0,0,4,1);
    add(1,0,0,  1,0,0,4,1); add(0,0,11, 0,0,0,4,2); add(1,0,0,  1,0,0,4,2);
    add(0,0,4,  0,1,0,4,3); add(0,1,0,  0,0,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rb, vecs[i].rs, vecs[i].sum);
      check($sformatf("vec%0d", i),
            {vecs[i].e_roll, vecs[i].e_win, vecs[i].e_lose, vecs[i].e_point, vecs[i].e_nroll});
    end

    // Illegal come-out roll, then saturate the roll counter with point 6.
    drive(1, 0, 0);
    drive(0, 0, 13);
    check("illegal_first", 11'b0);
    drive(1, 0, 0);
    drive(0, 0, 6);
    check("point6", {3'b000, 4'd6, 4'd1});
    for (int k = 1; k <= 16; k++) begin
      drive(1, 0, 0);
      drive(0, 0, 8);
      check($sformatf("sat%0d", k), {3'b000, 4'd6, 4'((k + 1 > 15) ? 15 : k + 1)});
    end
    drive(1, 0, 0);
    drive(0, 0, 6);
    check("sat_win", {3'b010, 4'd6, 4'd15});
    async_reset_check("reset_in_win");

    // Randomized play against the model.
    model_reset();
    begin
      logic rb;
      logic rs;
      logic [3:0] s;
      rb = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 2) == 0) rb = ~rb;
        rs = ($urandom_range(0, 5) == 0);
        s  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 12));
        drive(rb, rs, s);
        model_step(rb, rs, int'(s));
        check($sformatf("rand%0d", c), model_out());
        if ($urandom_range(0, 99) == 0) begin
          async_reset_check($sformatf("rand_rst%0d", c));
          model_reset();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
